ibuf_sbuf_row_sched: RTL and testbench
======================================

Name: ibuf_sbuf_row_sched

Overview:
- Row-level scheduler for the AXI→ibuf→sbuf feature path.
- Issues one DMA row fetch per input row into a ping-pong ibuf pair (bank 0/1) and counts write beats.
- Starts the ibuf→sbuf transfer engine on a full bank and raises feature-ready to compute once sbuf holds the row.
- Guarantees sbuf is never written while compute may still read it, and signals frame completion.

Parameters:
- LITEWIDTH, 32, width of AXI-lite config fields (iheight, iwidth)
- DEPTHWIDTH, 9, width of ciGroup
- BEATWIDTH, 20, width of per-row beat count (iwidth*ciGroup)
- ROWWIDTH, 12, width of row indices

Ports:
- I_clk  in  1  clock
- I_rst_n  in  1  asynchronous active-low reset
- I_ap_start  in  1  frame start; rising edge sampled
- I_iheight  in  LITEWIDTH  input rows per frame
- I_iwidth  in  LITEWIDTH  input pixels per row
- I_ciGroup  in  DEPTHWIDTH  channel groups per pixel
- O_rd_req  out  1  row fetch request; held until acked
- I_rd_ack  in  1  DMA accepted request
- O_rd_row  out  ROWWIDTH  row being requested
- O_rd_beats  out  BEATWIDTH  beats per row
- O_wr_bank  out  1  ibuf bank receiving beats
- I_feature_dv  in  1  one ibuf write beat
- O_trans_start  out  1  one-cycle pulse: move bank to sbuf
- O_trans_bank  out  1  bank being transferred
- I_trans_done  in  1  transfer finished pulse
- O_f_rdy  out  1  sbuf holds row O_f_row
- O_f_row  out  ROWWIDTH  row index in sbuf
- I_row_consumed  in  1  compute finished with sbuf row
- O_busy  out  1  frame in progress
- O_done  out  1  one-cycle frame-complete pulse
- O_err  out  1  sticky: beat with no open fetch

Behaviour:
- Reset: all outputs 0; FSM IDLE; bank flags empty; counters 0. O_err is cleared only by reset or by a new ap_start.
- Top FSM states: IDLE, CFG, RUN, FIN.
- IDLE→CFG on a rising edge of I_ap_start; the config inputs are latched on that cycle.
- CFG lasts 1 cycle: registers beats = iwidth*ciGroup, truncated to BEATWIDTH.
- CFG→FIN if iheight==0 or beats==0; otherwise CFG→RUN.
- RUN→FIN when consumed-row count == iheight.
- FIN→IDLE after 1 cycle; O_done is pulsed in FIN.
- O_busy = state != IDLE. Edge at cycle 0 → O_rd_req is first high at cycle 2.
- ap_start edges are ignored unless in IDLE.
- Fetch:
  - O_rd_req asserts in RUN when fetch_row < iheight, bank[fill_ptr] is empty, and no fetch is open.
  - O_rd_row=fetch_row and O_wr_bank=fill_ptr, held stable until I_rd_ack.
  - The cycle after ack, req drops and the fetch is open.
  - Beats are counted while open. On beat #beats: bank[fill_ptr]←full, fill_ptr toggles, fetch_row++, fetch closes.
  - A beat while no fetch is open sets O_err and is otherwise ignored.
- sbuf slot states: EMPTY, XFER, READY.
- EMPTY and bank[drain_ptr] full → O_trans_start pulse, O_trans_bank=drain_ptr, →XFER.
- XFER, I_trans_done → bank[drain_ptr] empty, drain_ptr toggles, O_f_rdy=1, O_f_row=sbuf_row, →READY.
- READY, I_row_consumed → O_f_rdy=0, sbuf_row++, consumed++, →EMPTY. The next trans_start is no earlier than the following cycle.
- Simultaneity and stray inputs:
  - A bank freed by trans_done becomes fetchable on the next cycle, not the same cycle.
  - A fetch completing and a trans_start on the other bank in the same cycle are both legal.
  - trans_done outside XFER and row_consumed outside READY are ignored.
  - ack without req is ignored.
- Throughput: at most 2 rows resident in ibuf plus 1 in sbuf.
- Asynchronous reset mid-frame returns to IDLE immediately; in-flight DMA beats after reset set O_err.

Decomposition:
- Shared package: FSM state encodings (IDLE/CFG/RUN/FIN, EMPTY/XFER/READY) and the ROWWIDTH/BEATWIDTH defaults.
- One natural sub-module, ibuf_bank_tracker: two full flags, fill/drain pointers, and the beat counter.

Test Plan:
- iheight=3, iwidth=4, ciGroup=2, immediate ack/done/consume → 3 fetches of O_rd_beats=8, O_rd_row 0,1,2. O_wr_bank 0,1,0. O_trans_bank 0,1,0. O_f_row 0,1,2. O_done once. O_err=0.
- Stall consume, iheight=4 → rows 0,1 fill both banks and row 2 is not requested until trans_done frees bank 0. No trans_start while O_f_rdy=1.
- Zero-work config: iheight=0 and, separately, iwidth=0 → O_done at cycle 3 (cycle-0 edge). No O_rd_req.
- ack delayed 5 cycles → O_rd_row and O_wr_bank stay stable, one fetch counted. A beat injected before ack sets O_err. The next ap_start clears O_err.
- I_rst_n low during XFER, then new frame iheight=2 → outputs 0 during reset, clean restart from row 0 and bank 0.
- ap_start pulse during RUN → ignored, row sequence unchanged, single O_done.

Source files
------------

// File: rtl/ibuf_sbuf_row_sched_pkg.sv
// Shared types for the row scheduler: frame FSM and sbuf slot encodings, default widths.
// No logic here; latency and backpressure live in the modules that import it.
package ibuf_sbuf_row_sched_pkg;

    localparam int LITEWIDTH_DEF  = 32;
    localparam int DEPTHWIDTH_DEF = 9;
    localparam int BEATWIDTH_DEF  = 20;
    localparam int ROWWIDTH_DEF   = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } top_state_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        XFER  = 2'd1,
        READY = 2'd2
    } slot_state_e;

endpackage

// File: rtl/ibuf_sbuf_row_sched_if.sv
// Scheduler-facing bundle: config, DMA row fetch, ibuf beats, ibuf->sbuf transfer, compute handoff.
// master = scheduler, slave = DMA / transfer engine / compute environment.
interface ibuf_sbuf_row_sched_if
    import ibuf_sbuf_row_sched_pkg::*;
#(
    parameter int LITEWIDTH  = LITEWIDTH_DEF,
    parameter int DEPTHWIDTH = DEPTHWIDTH_DEF,
    parameter int BEATWIDTH  = BEATWIDTH_DEF,
    parameter int ROWWIDTH   = ROWWIDTH_DEF
);
    logic                  I_ap_start;
    logic [LITEWIDTH-1:0]  I_iheight;
    logic [LITEWIDTH-1:0]  I_iwidth;
    logic [DEPTHWIDTH-1:0] I_ciGroup;
    logic                  O_rd_req;
    logic                  I_rd_ack;
    logic [ROWWIDTH-1:0]   O_rd_row;
    logic [BEATWIDTH-1:0]  O_rd_beats;
    logic                  O_wr_bank;
    logic                  I_feature_dv;
    logic                  O_trans_start;
    logic                  O_trans_bank;
    logic                  I_trans_done;
    logic                  O_f_rdy;
    logic [ROWWIDTH-1:0]   O_f_row;
    logic                  I_row_consumed;
    logic                  O_busy;
    logic                  O_done;
    logic                  O_err;

    modport master (
        input  I_ap_start, I_iheight, I_iwidth, I_ciGroup,
        input  I_rd_ack, I_feature_dv, I_trans_done, I_row_consumed,
        output O_rd_req, O_rd_row, O_rd_beats, O_wr_bank,
        output O_trans_start, O_trans_bank, O_f_rdy, O_f_row,
        output O_busy, O_done, O_err
    );

    modport slave (
        output I_ap_start, I_iheight, I_iwidth, I_ciGroup,
        output I_rd_ack, I_feature_dv, I_trans_done, I_row_consumed,
        input  O_rd_req, O_rd_row, O_rd_beats, O_wr_bank,
        input  O_trans_start, O_trans_bank, O_f_rdy, O_f_row,
        input  O_busy, O_done, O_err
    );

endinterface

// File: rtl/ibuf_sbuf_row_sched_ibuf_bank_tracker.sv
// Ping-pong ibuf bookkeeping: full flags, fill/drain pointers, open-fetch beat counter.
// Flag updates land one cycle after the causing event; beats with no open fetch are flagged, not counted.
module ibuf_bank_tracker #(
    parameter int BEATWIDTH = 20
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clear_i,
    input  logic [BEATWIDTH-1:0] beats_i,
    input  logic                 req_i,
    input  logic                 ack_i,
    input  logic                 beat_i,
    input  logic                 drain_done_i,
    output logic [1:0]           full_o,
    output logic                 fill_ptr_o,
    output logic                 drain_ptr_o,
    output logic                 open_o,
    output logic                 fetch_done_o,
    output logic                 stray_beat_o
);
    logic [1:0]           full_q, full_d;
    logic                 fill_q, fill_d;
    logic                 drain_q, drain_d;
    logic                 open_q, open_d;
    logic [BEATWIDTH-1:0] cnt_q, cnt_d;
    logic                 fetch_done;

    always_comb begin
        full_d     = full_q;
        fill_d     = fill_q;
        drain_d    = drain_q;
        open_d     = open_q;
        cnt_d      = cnt_q;
        fetch_done = open_q && beat_i && ((cnt_q + 1'b1) == beats_i);

        if (clear_i) begin
            full_d     = 2'b00;
            fill_d     = 1'b0;
            drain_d    = 1'b0;
            open_d     = 1'b0;
            cnt_d      = '0;
            fetch_done = 1'b0;
        end else begin
            if (req_i && ack_i) begin
                open_d = 1'b1;
                cnt_d  = '0;
            end
            // Fill and drain always target different banks, so both may update in one cycle.
            if (open_q && beat_i) begin
                if (fetch_done) begin
                    open_d         = 1'b0;
                    cnt_d          = '0;
                    full_d[fill_q] = 1'b1;
                    fill_d         = ~fill_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            if (drain_done_i) begin
                full_d[drain_q] = 1'b0;
                drain_d         = ~drain_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            full_q  <= 2'b00;
            fill_q  <= 1'b0;
            drain_q <= 1'b0;
            open_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            full_q  <= full_d;
            fill_q  <= fill_d;
            drain_q <= drain_d;
            open_q  <= open_d;
            cnt_q   <= cnt_d;
        end
    end

    assign full_o       = full_q;
    assign fill_ptr_o   = fill_q;
    assign drain_ptr_o  = drain_q;
    assign open_o       = open_q;
    assign fetch_done_o = fetch_done;
    assign stray_beat_o = beat_i && !open_q;

endmodule

// File: rtl/ibuf_sbuf_row_sched.sv
// Row scheduler AXI->ibuf->sbuf: one fetch per row into ping-pong ibuf, ibuf->sbuf transfer, compute handoff.
// First fetch request 2 cycles after ap_start edge; fetch stalls on full bank, transfer stalls while sbuf is READY.
module ibuf_sbuf_row_sched
    import ibuf_sbuf_row_sched_pkg::*;
#(
    parameter int LITEWIDTH  = LITEWIDTH_DEF,
    parameter int DEPTHWIDTH = DEPTHWIDTH_DEF,
    parameter int BEATWIDTH  = BEATWIDTH_DEF,
    parameter int ROWWIDTH   = ROWWIDTH_DEF
) (
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    ibuf_sbuf_row_sched_if.master bus
);
    top_state_e            state_q, state_d;
    slot_state_e           slot_q, slot_d;
    logic                  ap_start_q;
    logic [LITEWIDTH-1:0]  iheight_q, iheight_d;
    logic [LITEWIDTH-1:0]  iwidth_q, iwidth_d;
    logic [DEPTHWIDTH-1:0] cig_q, cig_d;
    logic [BEATWIDTH-1:0]  beats_q, beats_d;
    logic [ROWWIDTH-1:0]   fetch_row_q, fetch_row_d;
    logic [ROWWIDTH-1:0]   sbuf_row_q, sbuf_row_d;
    logic [ROWWIDTH-1:0]   consumed_q, consumed_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;

    logic                  frame_go, rd_req, trans_start, xfer_done;
    logic [1:0]            full;
    logic                  fill_ptr, drain_ptr, fetch_open, fetch_done, stray_beat;

    ibuf_bank_tracker #(.BEATWIDTH(BEATWIDTH)) u_bank (
        .clk_i        (I_clk),
        .rst_n_i      (I_rst_n),
        .clear_i      (frame_go),
        .beats_i      (beats_q),
        .req_i        (rd_req),
        .ack_i        (bus.I_rd_ack),
        .beat_i       (bus.I_feature_dv),
        .drain_done_i (xfer_done),
        .full_o       (full),
        .fill_ptr_o   (fill_ptr),
        .drain_ptr_o  (drain_ptr),
        .open_o       (fetch_open),
        .fetch_done_o (fetch_done),
        .stray_beat_o (stray_beat)
    );

    always_comb begin
        frame_go    = (state_q == IDLE) && bus.I_ap_start && !ap_start_q;
        rd_req      = (state_q == RUN) && (LITEWIDTH'(fetch_row_q) < iheight_q)
                      && !full[fill_ptr] && !fetch_open;
        trans_start = (state_q == RUN) && (slot_q == EMPTY) && full[drain_ptr];
        xfer_done   = (slot_q == XFER) && bus.I_trans_done;

        state_d     = state_q;
        slot_d      = slot_q;
        iheight_d   = iheight_q;
        iwidth_d    = iwidth_q;
        cig_d       = cig_q;
        beats_d     = beats_q;
        fetch_row_d = fetch_row_q;
        sbuf_row_d  = sbuf_row_q;
        consumed_d  = consumed_q;
        err_d       = err_q;
        done_d      = (state_q == FIN);

        case (state_q)
            IDLE: begin
                if (frame_go) begin
                    state_d   = CFG;
                    iheight_d = bus.I_iheight;
                    iwidth_d  = bus.I_iwidth;
                    cig_d     = bus.I_ciGroup;
                end
            end
            CFG: begin
                // Low bits of the product are exact even though the multiply itself wraps.
                beats_d = BEATWIDTH'(iwidth_q * LITEWIDTH'(cig_q));
                state_d = ((iheight_q == '0) || (beats_d == '0)) ? FIN : RUN;
            end
            RUN: begin
                if (LITEWIDTH'(consumed_q) == iheight_q) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (frame_go) begin
            slot_d      = EMPTY;
            fetch_row_d = '0;
            sbuf_row_d  = '0;
            consumed_d  = '0;
            err_d       = 1'b0;
        end else begin
            if (fetch_done) fetch_row_d = fetch_row_q + 1'b1;
            if (stray_beat) err_d = 1'b1;
            case (slot_q)
                EMPTY: if (trans_start) slot_d = XFER;
                XFER:  if (bus.I_trans_done) slot_d = READY;
                READY: begin
                    if (bus.I_row_consumed) begin
                        slot_d     = EMPTY;
                        sbuf_row_d = sbuf_row_q + 1'b1;
                        consumed_d = consumed_q + 1'b1;
                    end
                end
                default: slot_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= IDLE;
            slot_q      <= EMPTY;
            ap_start_q  <= 1'b0;
            iheight_q   <= '0;
            iwidth_q    <= '0;
            cig_q       <= '0;
            beats_q     <= '0;
            fetch_row_q <= '0;
            sbuf_row_q  <= '0;
            consumed_q  <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            ap_start_q  <= bus.I_ap_start;
            iheight_q   <= iheight_d;
            iwidth_q    <= iwidth_d;
            cig_q       <= cig_d;
            beats_q     <= beats_d;
            fetch_row_q <= fetch_row_d;
            sbuf_row_q  <= sbuf_row_d;
            consumed_q  <= consumed_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign bus.O_rd_req      = rd_req;
    assign bus.O_rd_row      = fetch_row_q;
    assign bus.O_rd_beats    = beats_q;
    assign bus.O_wr_bank     = fill_ptr;
    assign bus.O_trans_start = trans_start;
    assign bus.O_trans_bank  = drain_ptr;
    assign bus.O_f_rdy       = (slot_q == READY);
    assign bus.O_f_row       = sbuf_row_q;
    assign bus.O_busy        = (state_q != IDLE);
    assign bus.O_done        = done_q;
    assign bus.O_err         = err_q;

endmodule

// File: tb/tb_ibuf_sbuf_row_sched.sv
// Directed bench: a configurable DMA/transfer/compute responder logs events; main checks them against hand values.
module tb_ibuf_sbuf_row_sched;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ibuf_sbuf_row_sched_if bus ();

    ibuf_sbuf_row_sched dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    int ack_dly      = 0;
    int trans_dly    = 1;
    bit consume_en   = 1'b1;
    bit inject_stray = 1'b0;
    int epoch        = 0;

    int cyc = 0;
    int q_rd_row[$], q_wr_bank[$], q_rd_beats[$], q_req_cyc[$];
    int q_trans_bank[$], q_tdone_cyc[$], q_f_row[$];
    int n_done, stab_bad, tsf_bad, last_req_cycles;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Encodes a short sequence as nibbles of (value+1) so length mismatches are visible.
    function automatic int pack(input int q[$]);
        int v = 0;
        foreach (q[i]) v = (v << 4) | (q[i] + 1);
        return v;
    endfunction

    initial begin
        int seen_epoch = 0;
        int req_cnt    = 0;
        int beats_left = 0;
        int tdone_at   = -1;
        int hold_row   = 0;
        int hold_bank  = 0;
        bus.I_rd_ack       = 1'b0;
        bus.I_feature_dv   = 1'b0;
        bus.I_trans_done   = 1'b0;
        bus.I_row_consumed = 1'b0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (epoch != seen_epoch) begin
                seen_epoch = epoch;
                q_rd_row.delete(); q_wr_bank.delete(); q_rd_beats.delete(); q_req_cyc.delete();
                q_trans_bank.delete(); q_tdone_cyc.delete(); q_f_row.delete();
                n_done = 0; stab_bad = 0; tsf_bad = 0; last_req_cycles = 0; req_cnt = 0;
            end
            bus.I_rd_ack       = 1'b0;
            bus.I_feature_dv   = 1'b0;
            bus.I_trans_done   = 1'b0;
            bus.I_row_consumed = 1'b0;
            if (beats_left > 0) begin
                bus.I_feature_dv = 1'b1;
                beats_left--;
            end
            if (bus.O_rd_req) begin
                if (req_cnt == 0) begin
                    q_req_cyc.push_back(cyc);
                    hold_row  = int'(bus.O_rd_row);
                    hold_bank = int'(bus.O_wr_bank);
                end else if (int'(bus.O_rd_row) != hold_row || int'(bus.O_wr_bank) != hold_bank) begin
                    stab_bad++;
                end
                if (inject_stray && req_cnt == 2) bus.I_feature_dv = 1'b1;
                if (req_cnt >= ack_dly) begin
                    bus.I_rd_ack = 1'b1;
                    q_rd_row.push_back(int'(bus.O_rd_row));
                    q_wr_bank.push_back(int'(bus.O_wr_bank));
                    q_rd_beats.push_back(int'(bus.O_rd_beats));
                    beats_left      = int'(bus.O_rd_beats);
                    last_req_cycles = req_cnt + 1;
                    req_cnt         = 0;
                end else begin
                    req_cnt++;
                end
            end
            if (tdone_at == cyc) begin
                bus.I_trans_done = 1'b1;
                q_tdone_cyc.push_back(cyc);
                tdone_at = -1;
            end
            if (bus.O_trans_start) begin
                q_trans_bank.push_back(int'(bus.O_trans_bank));
                tdone_at = cyc + trans_dly;
            end
            if (bus.O_trans_start && bus.O_f_rdy) tsf_bad++;
            if (bus.O_f_rdy && consume_en) begin
                bus.I_row_consumed = 1'b1;
                q_f_row.push_back(int'(bus.O_f_row));
            end
            if (bus.O_done) n_done++;
        end
    end

    task automatic new_epoch();
        epoch = epoch + 1;
        repeat (2) @(negedge clk);
    endtask

    // Returns one negedge after the one that raised ap_start (i.e. in the CFG cycle).
    task automatic kick(input int ih, input int iw, input int cg);
        @(negedge clk);
        bus.I_iheight  = 32'(ih);
        bus.I_iwidth   = 32'(iw);
        bus.I_ciGroup  = 9'(cg);
        bus.I_ap_start = 1'b1;
        @(negedge clk);
        bus.I_ap_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.O_done) seen = 1'b1;
        end
        check_eq({tag, " done_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        bit ts_seen;
        rst_n          = 1'b0;
        bus.I_ap_start = 1'b0;
        bus.I_iheight  = '0;
        bus.I_iwidth   = '0;
        bus.I_ciGroup  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst rd_req",  32'(bus.O_rd_req), 0);
        check_eq("rst busy",    32'(bus.O_busy), 0);
        check_eq("rst done",    32'(bus.O_done), 0);
        check_eq("rst err",     32'(bus.O_err), 0);
        check_eq("rst f_rdy",   32'(bus.O_f_rdy), 0);
        check_eq("rst tstart",  32'(bus.O_trans_start), 0);
        rst_n = 1'b1;

        // Basic 3-row frame, immediate responses
        new_epoch();
        kick(3, 4, 2);
        wait_done(400, "t1");
        repeat (5) @(negedge clk);
        check_eq("t1 rd_row",     32'(pack(q_rd_row)), 32'h123);
        check_eq("t1 wr_bank",    32'(pack(q_wr_bank)), 32'h121);
        check_eq("t1 rd_beats",   32'(pack(q_rd_beats)), 32'h999);
        check_eq("t1 trans_bank", 32'(pack(q_trans_bank)), 32'h121);
        check_eq("t1 f_row",      32'(pack(q_f_row)), 32'h123);
        check_eq("t1 done_cnt",   32'(n_done), 1);
        check_eq("t1 err",        32'(bus.O_err), 0);
        check_eq("t1 busy",       32'(bus.O_busy), 0);

        // Stalled consumer, slow transfer: two banks plus one sbuf row, then drain
        new_epoch();
        consume_en = 1'b0;
        trans_dly  = 20;
        kick(4, 4, 2);
        check_eq("t2 req_cfg",  32'(bus.O_rd_req), 0);
        check_eq("t2 busy_cfg", 32'(bus.O_busy), 1);
        @(negedge clk);
        check_eq("t2 req_run",  32'(bus.O_rd_req), 1);
        repeat (150) @(negedge clk);
        check_eq("t2 stall rows",  32'(pack(q_rd_row)), 32'h123);
        check_eq("t2 stall banks", 32'(pack(q_wr_bank)), 32'h121);
        check_eq("t2 stall xfers", 32'(pack(q_trans_bank)), 32'h1);
        check_eq("t2 stall f_rdy", 32'(bus.O_f_rdy), 1);
        check_eq("t2 stall f_row", 32'(bus.O_f_row), 0);
        check_eq("t2 stall req",   32'(bus.O_rd_req), 0);
        check_eq("t2 row2 after free", 32'(q_req_cyc.size() > 2 && q_tdone_cyc.size() > 0 ?
                                           q_req_cyc[2] - q_tdone_cyc[0] : -1), 1);
        trans_dly  = 1;
        consume_en = 1'b1;
        wait_done(400, "t2");
        repeat (5) @(negedge clk);
        check_eq("t2 rd_row",     32'(pack(q_rd_row)), 32'h1234);
        check_eq("t2 trans_bank", 32'(pack(q_trans_bank)), 32'h1212);
        check_eq("t2 f_row",      32'(pack(q_f_row)), 32'h1234);
        check_eq("t2 tstart_vs_frdy", 32'(tsf_bad), 0);
        check_eq("t2 done_cnt",   32'(n_done), 1);

        // Zero-work frames: done in cycle 3 after the edge, no fetch
        new_epoch();
        kick(0, 4, 2);
        check_eq("t3a busy_c1", 32'(bus.O_busy), 1);
        check_eq("t3a done_c1", 32'(bus.O_done), 0);
        @(negedge clk);
        check_eq("t3a done_c2", 32'(bus.O_done), 0);
        @(negedge clk);
        check_eq("t3a done_c3", 32'(bus.O_done), 1);
        check_eq("t3a busy_c3", 32'(bus.O_busy), 0);
        @(negedge clk);
        check_eq("t3a done_c4", 32'(bus.O_done), 0);
        check_eq("t3a no_fetch", 32'(q_req_cyc.size()), 0);
        new_epoch();
        kick(3, 0, 2);
        @(negedge clk);
        check_eq("t3b done_c2", 32'(bus.O_done), 0);
        @(negedge clk);
        check_eq("t3b done_c3", 32'(bus.O_done), 1);
        repeat (3) @(negedge clk);
        check_eq("t3b no_fetch", 32'(q_req_cyc.size()), 0);

        // Delayed ack with a stray beat while the request is pending
        new_epoch();
        ack_dly      = 5;
        inject_stray = 1'b1;
        kick(1, 2, 1);
        wait_done(200, "t4");
        repeat (3) @(negedge clk);
        check_eq("t4 fetches",   32'(pack(q_rd_row)), 32'h1);
        check_eq("t4 req_cycles", 32'(last_req_cycles), 6);
        check_eq("t4 stable",    32'(stab_bad), 0);
        check_eq("t4 err",       32'(bus.O_err), 1);
        check_eq("t4 done_cnt",  32'(n_done), 1);
        ack_dly      = 0;
        inject_stray = 1'b0;
        kick(0, 1, 1);
        check_eq("t4 err_cleared", 32'(bus.O_err), 0);
        repeat (4) @(negedge clk);

        // Reset during XFER, then a clean 2-row frame
        new_epoch();
        kick(3, 4, 2);
        ts_seen = 1'b0;
        for (int i = 0; i < 100 && !ts_seen; i++) begin
            @(negedge clk);
            if (bus.O_trans_start) ts_seen = 1'b1;
        end
        check_eq("t5 tstart_seen", 32'(ts_seen), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("t5 rst busy",   32'(bus.O_busy), 0);
        check_eq("t5 rst req",    32'(bus.O_rd_req), 0);
        check_eq("t5 rst f_rdy",  32'(bus.O_f_rdy), 0);
        check_eq("t5 rst tstart", 32'(bus.O_trans_start), 0);
        check_eq("t5 rst row",    32'(bus.O_rd_row), 0);
        check_eq("t5 rst bank",   32'(bus.O_wr_bank), 0);
        check_eq("t5 rst err",    32'(bus.O_err), 0);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("t5 err_inflight", 32'(bus.O_err), 1);
        new_epoch();
        kick(2, 4, 2);
        check_eq("t5 err_cleared", 32'(bus.O_err), 0);
        wait_done(300, "t5");
        repeat (5) @(negedge clk);
        check_eq("t5 rd_row",     32'(pack(q_rd_row)), 32'h12);
        check_eq("t5 wr_bank",    32'(pack(q_wr_bank)), 32'h12);
        check_eq("t5 trans_bank", 32'(pack(q_trans_bank)), 32'h12);
        check_eq("t5 f_row",      32'(pack(q_f_row)), 32'h12);
        check_eq("t5 done_cnt",   32'(n_done), 1);

        // ap_start edge during RUN must be ignored
        new_epoch();
        kick(3, 4, 2);
        repeat (6) @(negedge clk);
        bus.I_iheight  = 32'd1;
        bus.I_ap_start = 1'b1;
        @(negedge clk);
        bus.I_ap_start = 1'b0;
        wait_done(400, "t6");
        repeat (20) @(negedge clk);
        check_eq("t6 rd_row",   32'(pack(q_rd_row)), 32'h123);
        check_eq("t6 f_row",    32'(pack(q_f_row)), 32'h123);
        check_eq("t6 done_cnt", 32'(n_done), 1);
        check_eq("t6 err",      32'(bus.O_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
